// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types for the two-master SDRAM port arbiter.
//   arb_state_t : arbiter FSM states
//   port_id_t   : master identifier carried in the read tag FIFO
//   arb_pick()  : fixed-priority pick with forced port-1 override
package sdram_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 22;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

   typedef logic port_id_t;

   // Port 0 wins unless port 1 has been starved long enough to be forced.
   function automatic arb_state_t arb_pick(input logic req0, input logic req1,
                                           input logic force1);
      if (req1 && force1) return GRANT1;
      if (req0)           return GRANT0;
      if (req1)           return GRANT1;
      return IDLE;
   endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: DEPTH x 1-bit FIFO holding the issuing port of each
// outstanding read. Push while full and pop while empty are ignored;
// simultaneous push/pop leaves the count unchanged.
//   i_clk, i_rst_n : clock, async active-low reset (flushes FIFO)
//   i_push, i_tag  : write a tag
//   i_pop          : drop the head tag
//   o_head         : tag at head
//   o_full/o_empty : occupancy flags
module arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_push,
   input  port_id_t i_tag,
   input  logic     i_pop,
   output port_id_t o_head,
   output logic     o_full,
   output logic     o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] r_mem;
   logic [PW-1:0]    r_wr, r_rd;
   logic [PW:0]      r_cnt;
   logic             w_push, w_pop;

   assign o_full  = (r_cnt == FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_tag;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master Avalon-MM arbiter in front of the SDRAM
// controller slave. Port 0 (DAC playback) has priority; port 1 (CPU/loader)
// is forced after STARVE_LIMIT consecutive port-0 acceptances. Pipelined
// read beats are routed back through a tag FIFO of MAX_PEND entries.
//   clk_clk, reset_reset_n   : clock, async active-low reset
//   p0_*/p1_*                : master ports (address/read/write/writedata/
//                              byteenable in; waitrequest/readdata/
//                              readdatavalid out)
//   s_*                      : slave side toward the SDRAM controller
// Optional: define ARB_STATS_EN to add p0_grant_cnt, p1_grant_cnt and
// p1_stall_max statistics outputs.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned MAX_PEND     = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [ADDR_W-1:0]   p0_address,
   input  logic                p0_read,
   input  logic                p0_write,
   input  logic [DATA_W-1:0]   p0_writedata,
   input  logic [DATA_W/8-1:0] p0_byteenable,
   output logic                p0_waitrequest,
   output logic [DATA_W-1:0]   p0_readdata,
   output logic                p0_readdatavalid,
   input  logic [ADDR_W-1:0]   p1_address,
   input  logic                p1_read,
   input  logic                p1_write,
   input  logic [DATA_W-1:0]   p1_writedata,
   input  logic [DATA_W/8-1:0] p1_byteenable,
   output logic                p1_waitrequest,
   output logic [DATA_W-1:0]   p1_readdata,
   output logic                p1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]         p0_grant_cnt,
   output logic [15:0]         p1_grant_cnt,
   output logic [15:0]         p1_stall_max
`endif
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   // Reset asserts asynchronously and releases on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) r_rst_sync <= '0;
      else                r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   arb_state_t          r_state, w_state_nxt;
   logic [SW-1:0]       r_starve, w_starve_nxt;
   logic                w_req0, w_req1;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [DATA_W/8-1:0] w_sel_be;
   logic                w_sel_rd, w_sel_wr, w_stall;
   port_id_t            w_gid, w_head;
   logic                w_full, w_empty;
   logic                w_acc, w_acc0, w_acc1;

   assign w_req0 = p0_read | p0_write;
   assign w_req1 = p1_read | p1_write;

   always_comb begin
      w_sel_addr  = p0_address;
      w_sel_wdata = p0_writedata;
      w_sel_be    = p0_byteenable;
      w_sel_rd    = 1'b0;
      w_sel_wr    = 1'b0;
      w_gid       = 1'b0;
      unique case (r_state)
         GRANT0: begin
            w_sel_rd = p0_read;
            w_sel_wr = p0_write;
         end
         GRANT1: begin
            w_sel_addr  = p1_address;
            w_sel_wdata = p1_writedata;
            w_sel_be    = p1_byteenable;
            w_sel_rd    = p1_read;
            w_sel_wr    = p1_write;
            w_gid       = 1'b1;
         end
         default: ;
      endcase
   end

   // Read wins over a simultaneous write; reads are held off while the
   // tag FIFO is full, writes are not.
   assign s_address    = w_sel_addr;
   assign s_writedata  = w_sel_wdata;
   assign s_byteenable = w_sel_be;
   assign s_read       = w_sel_rd & ~w_full;
   assign s_write      = w_sel_wr & ~w_sel_rd;
   assign w_stall      = w_sel_rd ? (w_full | s_waitrequest) : s_waitrequest;

   assign p0_waitrequest = (r_state != GRANT0) | w_stall;
   assign p1_waitrequest = (r_state != GRANT1) | w_stall;

   assign w_acc  = (s_read | s_write) & ~s_waitrequest;
   assign w_acc0 = w_acc & (r_state == GRANT0);
   assign w_acc1 = w_acc & (r_state == GRANT1);

   // Arbitration looks at the post-update starve count so the acceptance
   // that reaches the limit hands the very next grant to port 1.
   always_comb begin
      w_starve_nxt = r_starve;
      if (!w_req1 || w_acc1)                    w_starve_nxt = '0;
      else if (w_acc0 && r_starve != STARVE_MAX) w_starve_nxt = r_starve + 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    w_state_nxt = arb_pick(w_req0, w_req1, w_starve_nxt == STARVE_MAX);
         GRANT0: begin
            if (w_acc)        w_state_nxt = arb_pick(w_req0, w_req1, w_starve_nxt == STARVE_MAX);
            else if (!w_req0) w_state_nxt = IDLE;
         end
         GRANT1: begin
            if (w_acc)        w_state_nxt = arb_pick(w_req0, w_req1, w_starve_nxt == STARVE_MAX);
            else if (!w_req1) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= IDLE;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   arb_tag_fifo #(.DEPTH(MAX_PEND)) u_tag_fifo (
      .i_clk   (clk_clk),
      .i_rst_n (w_rst_n),
      .i_push  (w_acc & s_read),
      .i_tag   (w_gid),
      .i_pop   (s_readdatavalid),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Beats arriving with no outstanding tag are dropped.
   assign p0_readdata      = s_readdata;
   assign p1_readdata      = s_readdata;
   assign p0_readdatavalid = s_readdatavalid & ~w_empty & (w_head == 1'b0);
   assign p1_readdatavalid = s_readdatavalid & ~w_empty & (w_head == 1'b1);

`ifdef ARB_STATS_EN
   logic [15:0] r_p0_cnt, r_p1_cnt, r_run, r_max, w_run_nxt;

   always_comb begin
      w_run_nxt = r_run;
      if (!w_req1 || w_acc1) w_run_nxt = '0;
      else if (r_run != '1)  w_run_nxt = r_run + 1'b1;
   end

   always_ff @(posedge clk_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_p0_cnt <= '0;
         r_p1_cnt <= '0;
         r_run    <= '0;
         r_max    <= '0;
      end else begin
         if (w_acc0 && r_p0_cnt != '1) r_p0_cnt <= r_p0_cnt + 1'b1;
         if (w_acc1 && r_p1_cnt != '1) r_p1_cnt <= r_p1_cnt + 1'b1;
         r_run <= w_run_nxt;
         if (w_run_nxt > r_max) r_max <= w_run_nxt;
      end
   end

   assign p0_grant_cnt = r_p0_cnt;
   assign p1_grant_cnt = r_p1_cnt;
   assign p1_stall_max = r_max;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [21:0] p0_address, p1_address, s_address;
   logic        p0_read, p1_read, p0_write, p1_write;
   logic [31:0] p0_writedata, p1_writedata, s_writedata;
   logic [3:0]  p0_byteenable, p1_byteenable, s_byteenable;
   logic        p0_waitrequest, p1_waitrequest;
   logic [31:0] p0_readdata, p1_readdata, s_readdata;
   logic        p0_readdatavalid, p1_readdatavalid;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
`ifdef ARB_STATS_EN
   logic [15:0] p0_grant_cnt, p1_grant_cnt, p1_stall_max;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .ADDR_W(22), .DATA_W(32), .MAX_PEND(8), .STARVE_LIMIT(16)
   ) dut (
      .clk_clk          (clk),
      .reset_reset_n    (rst_n),
      .p0_address       (p0_address),
      .p0_read          (p0_read),
      .p0_write         (p0_write),
      .p0_writedata     (p0_writedata),
      .p0_byteenable    (p0_byteenable),
      .p0_waitrequest   (p0_waitrequest),
      .p0_readdata      (p0_readdata),
      .p0_readdatavalid (p0_readdatavalid),
      .p1_address       (p1_address),
      .p1_read          (p1_read),
      .p1_write         (p1_write),
      .p1_writedata     (p1_writedata),
      .p1_byteenable    (p1_byteenable),
      .p1_waitrequest   (p1_waitrequest),
      .p1_readdata      (p1_readdata),
      .p1_readdatavalid (p1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid)
`ifdef ARB_STATS_EN
      ,
      .p0_grant_cnt     (p0_grant_cnt),
      .p1_grant_cnt     (p1_grant_cnt),
      .p1_stall_max     (p1_stall_max)
`endif
   );

   // SDRAM controller stand-in: fixed 3-stage read pipeline, data derived
   // from the accepted address. Manual drive used when mdl_en is low.
   logic        mdl_en, man_rdv;
   logic [31:0] man_data;
   logic [2:0]  pv;
   logic [21:0] pa0, pa1, pa2;

   function automatic logic [31:0] rdat(input logic [21:0] a);
      return {10'h35A, a} ^ 32'h0F0F_0F0F;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv <= '0;
      end else begin
         pv  <= {pv[1:0], s_read & ~s_waitrequest};
         pa0 <= s_address;
         pa1 <= pa0;
         pa2 <= pa1;
      end
   end

   assign s_readdatavalid = mdl_en ? pv[2] : man_rdv;
   assign s_readdata      = mdl_en ? rdat(pa2) : man_data;

   // Beat collector: {port, data} in arrival order.
   logic [32:0] bq[$];
   always @(negedge clk) begin
      if (p0_readdatavalid) bq.push_back({1'b0, p0_readdata});
      if (p1_readdatavalid) bq.push_back({1'b1, p1_readdata});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One single-beat transfer; ok=1 if the port saw waitrequest low in time.
   task automatic xfer(input logic port, input logic wr, input logic [21:0] a,
                       input logic [31:0] d, output logic ok);
      ok = 1'b0;
      if (!port) begin
         p0_address = a; p0_writedata = d; p0_byteenable = 4'hF;
         p0_read = ~wr; p0_write = wr;
      end else begin
         p1_address = a; p1_writedata = d; p1_byteenable = 4'hF;
         p1_read = ~wr; p1_write = wr;
      end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((port ? p1_waitrequest : p0_waitrequest) == 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      if (!port) begin p0_read = 1'b0; p0_write = 1'b0; end
      else       begin p1_read = 1'b0; p1_write = 1'b0; end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ok;
      logic [32:0] exp_b[4];
      logic [32:0] got;

      p0_address = '0; p1_address = '0; p0_read = 0; p1_read = 0;
      p0_write = 0; p1_write = 0; p0_writedata = '0; p1_writedata = '0;
      p0_byteenable = '0; p1_byteenable = '0; s_waitrequest = 0;
      mdl_en = 0; man_rdv = 0; man_data = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_wait", {p0_waitrequest, p1_waitrequest}, 2'b11);
      chk("rst_srw", {s_read, s_write}, 2'b00);
      chk("rst_rdv", {p0_readdatavalid, p1_readdatavalid}, 2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) tick();
      chk("post_rst_wait", {p0_waitrequest, p1_waitrequest}, 2'b11);

      // A: lone port-1 write, one-cycle grant latency
      p1_address = 22'h000100; p1_writedata = 32'hDEADBEEF; p1_byteenable = 4'hF;
      p1_write = 1'b1;
      #1 chk("A_idle_wait", p1_waitrequest, 1'b1);
      tick();
      chk("A_s_write", {s_write, s_read}, 2'b10);
      chk("A_s_addr", s_address, 22'h000100);
      chk("A_s_data", s_writedata, 32'hDEADBEEF);
      chk("A_s_be", s_byteenable, 4'hF);
      chk("A_wait", {p0_waitrequest, p1_waitrequest}, 2'b10);
      tick();
      p1_write = 1'b0;
      #1 chk("A_drop", s_write, 1'b0);
      repeat (2) tick();

      // B: both writing continuously -> 16 x p0, 1 x p1, repeating
      p0_address = 22'h200; p1_address = 22'h300;
      p0_byteenable = 4'hF; p0_writedata = 32'h11; p1_writedata = 32'h22;
      p0_write = 1'b1; p1_write = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         tick();
         chk($sformatf("B_cyc%0d", i), {p0_waitrequest, p1_waitrequest},
             (i == 17 || i == 34) ? 2'b10 : 2'b01);
      end
      p0_write = 1'b0; p1_write = 1'b0;
      repeat (2) tick();

      // C: interleaved reads p0,p1,p0,p0 through the latency-3 model
      mdl_en = 1'b1;
      bq.delete();
      xfer(1'b0, 1'b0, 22'h10, '0, ok); chk("C_rd0", ok, 1'b1);
      xfer(1'b1, 1'b0, 22'h20, '0, ok); chk("C_rd1", ok, 1'b1);
      xfer(1'b0, 1'b0, 22'h30, '0, ok); chk("C_rd2", ok, 1'b1);
      xfer(1'b0, 1'b0, 22'h40, '0, ok); chk("C_rd3", ok, 1'b1);
      repeat (8) tick();
      chk("C_nbeats", bq.size(), 4);
      exp_b[0] = {1'b0, rdat(22'h10)};
      exp_b[1] = {1'b1, rdat(22'h20)};
      exp_b[2] = {1'b0, rdat(22'h30)};
      exp_b[3] = {1'b0, rdat(22'h40)};
      for (int k = 0; k < 4; k++) begin
         got = (k < bq.size()) ? bq[k] : '1;
         chk($sformatf("C_beat%0d", k), got, exp_b[k]);
      end

      // E: slave stalls a p0 read for 5 cycles while p1 also requests
      s_waitrequest = 1'b1;
      p0_address = 22'h55; p0_read = 1'b1;
      p1_address = 22'h66; p1_write = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("E_hold%0d", i), {s_read, s_address}, {1'b1, 22'h55});
         chk($sformatf("E_p1wait%0d", i), p1_waitrequest, 1'b1);
         tick();
      end
      s_waitrequest = 1'b0;
      #1 chk("E_release", p0_waitrequest, 1'b0);
      tick();
      p0_read = 1'b0; p1_write = 1'b0;
      repeat (6) tick();

      // F: reset with two reads pending, then a stray beat
      mdl_en = 1'b0; man_rdv = 1'b0;
      xfer(1'b0, 1'b0, 22'h61, '0, ok); chk("F_rd0", ok, 1'b1);
      xfer(1'b1, 1'b0, 22'h62, '0, ok); chk("F_rd1", ok, 1'b1);
      s_waitrequest = 1'b1;
      p0_address = 22'h63; p0_read = 1'b1;
      repeat (2) tick();
      chk("F_pre", s_read, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("F_rst_wait", {p0_waitrequest, p1_waitrequest}, 2'b11);
      chk("F_rst_srw", {s_read, s_write}, 2'b00);
      p0_read = 1'b0; s_waitrequest = 1'b0;
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      repeat (4) tick();
      man_data = 32'hBAD0BAD0; man_rdv = 1'b1;
      #1 chk("F_stray", {p0_readdatavalid, p1_readdatavalid}, 2'b00);
      tick();
      man_rdv = 1'b0;
      tick();

      // D: fill the tag FIFO, write still passes, 9th read waits for a pop
      for (int k = 0; k < 8; k++) begin
         xfer(1'b0, 1'b0, 22'(32'h80 + k), '0, ok);
         chk($sformatf("D_rd%0d", k), ok, 1'b1);
      end
      xfer(1'b1, 1'b1, 22'h90, 32'h12345678, ok);
      chk("D_full_wr", ok, 1'b1);
      p0_address = 22'h99; p0_read = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("D_held%0d", i), {p0_waitrequest, s_read}, 2'b10);
         tick();
      end
      man_data = 32'h0000CAFE; man_rdv = 1'b1;
      #1;
      chk("D_pop_rdv", {p0_readdatavalid, p1_readdatavalid}, 2'b10);
      chk("D_pop_hold", {p0_waitrequest, s_read}, 2'b10);
      tick();
      man_rdv = 1'b0;
      #1 chk("D_after_pop", {p0_waitrequest, s_read}, 2'b01);
      tick();
      p0_read = 1'b0;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
